bus_decoder_nslave: RTL

- Parametrised, registered successor to the flat 3-target bus decoder.
- Decodes one master's address field into NUM_SLV slave selects and runs a single-outstanding request/acknowledge transaction per access.
- Returns read data from the addressed slave, and flags unmapped addresses, conflicting strobes and slave timeouts as errors.
- Sits between the core's data port and the RAM/UART/GPIO/accelerator peripherals.

---
 rtl/bus_decoder_nslave.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_decoder_nslave.sv
// Purpose: decodes m_addr[SEL_HI:SEL_LO] into NUM_SLV one-hot slave selects.
//   It runs one outstanding request/ack transaction at a time.
//   Unmapped addresses, conflicting strobes and slave timeouts are reported as errors.
// Latency: accept in cycle N, strobes in N+1; an ack in N+1 gives m_done in N+2.
//   Error decodes also complete in N+2.
// Backpressure: m_ready is low from N+1 until the m_done cycle has passed.
//   Requests presented while m_ready is low are ignored.
// Optional: define BUS_DEC_ERRCNT_EN to add the saturating err_cnt output.
module bus_decoder_nslave #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_HI  = 31,
    parameter int SEL_LO  = 28,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_re,
    input  logic                      m_we,
    output logic                      m_ready,
    output logic                      m_done,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_err,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [NUM_SLV-1:0]        s_sel,
    output logic [NUM_SLV-1:0]        s_re,
    output logic [NUM_SLV-1:0]        s_we,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ack
`ifdef BUS_DEC_ERRCNT_EN
    ,
    output logic [15:0]               err_cnt
`endif
);

    localparam int RW = SEL_HI - SEL_LO + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
    logic [DATA_W-1:0]  s_wdata_q, s_wdata_d;
    logic [NUM_SLV-1:0] s_sel_q, s_sel_d;
    logic [NUM_SLV-1:0] s_re_q, s_re_d;
    logic [NUM_SLV-1:0] s_we_q, s_we_d;
    logic [DATA_W-1:0]  m_rdata_q, m_rdata_d;
    logic               m_err_q, m_err_d;
    // Set when the accepted request was unmapped or had both re and we high:
    // it spends one strobe-less ACCESS cycle so error completions keep the
    // same N+2 latency as a zero-wait access.
    logic               err_pend_q, err_pend_d;

    logic [RW-1:0]      region;
    logic [4:0]         region_x;
    logic               mapped;
    logic [3:0]         idx;
    logic [NUM_SLV-1:0] dec_sel;
    logic               ack_hit;
    logic [DATA_W-1:0]  sel_rdata;

    assign region   = m_addr[SEL_HI:SEL_LO];
    assign region_x = {{(5-RW){1'b0}}, region};
    assign mapped   = (region_x != 5'd0) && (region_x <= 5'(NUM_SLV));
    assign idx      = 4'(region_x - 5'd1);

    // Only the selected slave's ack counts; others are masked off by s_sel.
    assign ack_hit  = |(s_ack & s_sel_q);

    // One-hot decode of the region index and read-data mux of the selected slave.
    always_comb begin
        dec_sel   = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            dec_sel[i] = (idx == 4'(i));
            if (s_sel_q[i]) begin
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM: accept in IDLE, hold strobes in ACCESS, report in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_sel_d    = s_sel_q;
        s_re_d     = s_re_q;
        s_we_d     = s_we_q;
        m_rdata_d  = m_rdata_q;
        m_err_d    = m_err_q;
        err_pend_d = err_pend_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_re | m_we) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    state_d   = ACCESS;
                    if (mapped && (m_re ^ m_we)) begin
                        s_sel_d    = dec_sel;
                        s_re_d     = m_re ? dec_sel : '0;
                        s_we_d     = m_we ? dec_sel : '0;
                        err_pend_d = 1'b0;
                    end else begin
                        s_sel_d    = '0;
                        s_re_d     = '0;
                        s_we_d     = '0;
                        err_pend_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (err_pend_q) begin
                    m_err_d    = 1'b1;
                    m_rdata_d  = '0;
                    err_pend_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    // Ack is checked first so an ack on the timeout cycle wins.
                    if (ack_hit) begin
                        if (|s_re_q) begin
                            m_rdata_d = sel_rdata;
                        end
                        m_err_d = 1'b0;
                        s_sel_d = '0;
                        s_re_d  = '0;
                        s_we_d  = '0;
                        state_d = RESP;
                    end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        s_sel_d   = '0;
                        s_re_d    = '0;
                        s_we_d    = '0;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                s_sel_d    = '0;
                s_re_d     = '0;
                s_we_d     = '0;
                err_pend_d = 1'b0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_sel_q    <= '0;
            s_re_q     <= '0;
            s_we_q     <= '0;
            m_rdata_q  <= '0;
            m_err_q    <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_sel_q    <= s_sel_d;
            s_re_q     <= s_re_d;
            s_we_q     <= s_we_d;
            m_rdata_q  <= m_rdata_d;
            m_err_q    <= m_err_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign m_ready = (state_q == IDLE);
    assign m_done  = (state_q == RESP);
    assign m_rdata = m_rdata_q;
    assign m_err   = m_err_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_sel   = s_sel_q;
    assign s_re    = s_re_q;
    assign s_we    = s_we_q;

`ifdef BUS_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Count error completions, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((state_q == RESP) && m_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
